// File: rtl/dmem_master.sv
// Data memory port sequencer: one load/store per handshake, legality checked up front,
// single-cycle memory access, result held until the consumer accepts it.
module dmem_master #(
    parameter int XLEN             = 32,
    parameter int FLEN             = 64,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [63:0]     req_wdata,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [63:0]     resp_rdata,
    output logic            resp_error,
    output logic [XLEN-1:0] mem_addr,
    output logic [63:0]     mem_write_data,
    output logic            mem_read,
    output logic            mem_write,
    output logic [2:0]      mem_funct3,
    input  logic [63:0]     mem_read_data
);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // ACCESS | one-cycle memory read or write from the request registers
    // RESP   | response held until resp_ready
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] addr_q;
    logic [63:0]     wdata_q;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [63:0]     rdata_q;
    logic            error_q;
    logic            req_illegal;
    logic            misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign req_illegal = (req_we && req_funct3[2])
                      || (!req_we && req_funct3 == 3'b111)
                      || (req_funct3 == 3'b011 && XLEN == 32 && FLEN < 64)
                      || (req_funct3 == 3'b110 && XLEN == 32)
                      || (ALLOW_MISALIGNED == 0 && misaligned);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        rdata_q  <= '0;
                        error_q  <= req_illegal;
                        state    <= req_illegal ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // memory already sign/zero-extends, so capture raw
                    rdata_q <= we_q ? 64'd0 : mem_read_data;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // strobes decode from state only, so an async reset kills them at once
    assign req_ready      = (state == ST_IDLE);
    assign resp_valid     = (state == ST_RESP);
    assign resp_rdata     = rdata_q;
    assign resp_error     = error_q;
    assign mem_read       = (state == ST_ACCESS) && !we_q;
    assign mem_write      = (state == ST_ACCESS) && we_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_funct3     = funct3_q;

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: two instances (permissive RV32+D, strict RV32 without D),
// each with its own byte memory, checked against a byte-array reference model.
module tb_dmem_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr [2];
    logic [63:0] req_wdata [2];
    logic        req_we [2];
    logic [2:0]  req_funct3 [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [63:0] resp_rdata [2];
    logic        resp_error [2];
    logic [31:0] mem_addr [2];
    logic [63:0] mem_write_data [2];
    logic        mem_read [2];
    logic        mem_write [2];
    logic [2:0]  mem_funct3 [2];
    logic [63:0] mem_read_data [2];

    logic [7:0] mem [2][1024] = '{default: 8'h00};
    logic [7:0] model_mem [2][1024] = '{default: 8'h00};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_master #(.XLEN(32), .FLEN(64), .ALLOW_MISALIGNED(1)) u0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_we(req_we[0]), .req_funct3(req_funct3[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_error(resp_error[0]), .mem_addr(mem_addr[0]), .mem_write_data(mem_write_data[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_funct3(mem_funct3[0]),
        .mem_read_data(mem_read_data[0]));

    dmem_master #(.XLEN(32), .FLEN(32), .ALLOW_MISALIGNED(0)) u1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_we(req_we[1]), .req_funct3(req_funct3[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_error(resp_error[1]), .mem_addr(mem_addr[1]), .mem_write_data(mem_write_data[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_funct3(mem_funct3[1]),
        .mem_read_data(mem_read_data[1]));

    // Memory: combinational extending read, posedge sized write
    for (genvar g = 0; g < 2; g++) begin : g_mem
        always_comb begin
            logic [63:0] raw;
            raw = '0;
            for (int k = 0; k < 8; k++)
                raw[k*8 +: 8] = mem[g][10'(int'(mem_addr[g][9:0]) + k)];
            case (mem_funct3[g])
                3'b000:  mem_read_data[g] = {{56{raw[7]}}, raw[7:0]};
                3'b001:  mem_read_data[g] = {{48{raw[15]}}, raw[15:0]};
                3'b010:  mem_read_data[g] = {{32{raw[31]}}, raw[31:0]};
                3'b100:  mem_read_data[g] = {56'd0, raw[7:0]};
                3'b101:  mem_read_data[g] = {48'd0, raw[15:0]};
                3'b110:  mem_read_data[g] = {32'd0, raw[31:0]};
                default: mem_read_data[g] = raw;
            endcase
        end
        always @(posedge clk) begin
            if (mem_write[g])
                for (int k = 0; k < 8; k++)
                    if (k < (1 << mem_funct3[g][1:0]))
                        mem[g][10'(int'(mem_addr[g][9:0]) + k)] <= mem_write_data[g][k*8 +: 8];
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: legality rules and byte-level memory
    function automatic bit model_err(int i, logic we, logic [2:0] f3, logic [31:0] a);
        int flen = (i == 0) ? 64 : 32;
        bit strict = (i == 1);
        int size = 1 << f3[1:0];
        if (we && f3 >= 4) return 1;
        if (!we && f3 == 7) return 1;
        if (f3 == 3 && flen < 64) return 1;
        if (f3 == 6) return 1;
        if (strict && (a % size) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [63:0] model_load(int i, logic [31:0] a, logic [2:0] f3);
        int size = 1 << f3[1:0];
        logic [63:0] v = 0;
        for (int k = 0; k < size; k++) v = v + (64'(model_mem[i][a + k]) << (8 * k));
        if (!f3[2] && size < 8 && v[8*size-1]) v = v - (64'd1 << (8 * size));
        return v;
    endfunction

    task automatic model_store(int i, logic [31:0] a, logic [63:0] wd, logic [2:0] f3);
        for (int k = 0; k < (1 << f3[1:0]); k++) model_mem[i][a + k] = wd[8*k +: 8];
    endtask

    task automatic do_req(input int i, input logic [31:0] a, input logic [63:0] wd,
                          input logic w, input logic [2:0] f3, input int hold,
                          output logic [63:0] rd, output logic er, output int lat,
                          output int nwr, output int nrd);
        @(negedge clk);
        check("req_ready_idle", req_ready[i], 1'b1);
        req_addr[i] = a; req_wdata[i] = wd; req_we[i] = w; req_funct3[i] = f3;
        req_valid[i] = 1'b1;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        lat = 0; nwr = 0; nrd = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            nwr += int'(mem_write[i]);
            nrd += int'(mem_read[i]);
            if (resp_valid[i]) break;
        end
        if (!resp_valid[i]) begin
            check("resp_timeout", 1'b0, 1'b1);
            rd = '0; er = 1'b0;
            return;
        end
        rd = resp_rdata[i]; er = resp_error[i];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", resp_valid[i], 1'b1);
            check("hold_rdata", resp_rdata[i], rd);
            check("hold_error", resp_error[i], er);
            check("hold_req_ready", req_ready[i], 1'b0);
            nwr += int'(mem_write[i]);
            nrd += int'(mem_read[i]);
        end
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        resp_ready[i] = 1'b0;
        check("resp_valid_drop", resp_valid[i], 1'b0);
        check("req_ready_back", req_ready[i], 1'b1);
    endtask

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic [2:0]  f3;
        int          hold;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [19];

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic er;
        int lat, nwr, nrd;

        vecs[0]  = '{0, 32'h100, 64'hDEADBEEF, 1'b1, 3'b010, 0, 64'h0, 1'b0};
        vecs[1]  = '{0, 32'h100, 64'h0, 1'b0, 3'b010, 0, 64'hFFFFFFFF_DEADBEEF, 1'b0};
        vecs[2]  = '{0, 32'h203, 64'h80, 1'b1, 3'b000, 0, 64'h0, 1'b0};
        vecs[3]  = '{0, 32'h203, 64'h0, 1'b0, 3'b000, 0, 64'hFFFFFFFF_FFFFFF80, 1'b0};
        vecs[4]  = '{0, 32'h203, 64'h0, 1'b0, 3'b100, 0, 64'h80, 1'b0};
        vecs[5]  = '{1, 32'h102, 64'h0, 1'b0, 3'b010, 0, 64'h0, 1'b1};
        vecs[6]  = '{0, 32'h102, 64'h0, 1'b0, 3'b010, 0, 64'h0000DEAD, 1'b0};
        vecs[7]  = '{0, 32'h100, 64'h0, 1'b0, 3'b011, 0, 64'hDEADBEEF, 1'b0};
        vecs[8]  = '{0, 32'h100, 64'h0, 1'b0, 3'b010, 5, 64'hFFFFFFFF_DEADBEEF, 1'b0};
        vecs[9]  = '{0, 32'h100, 64'h11, 1'b1, 3'b100, 0, 64'h0, 1'b1};
        vecs[10] = '{0, 32'h100, 64'h0, 1'b0, 3'b010, 0, 64'hFFFFFFFF_DEADBEEF, 1'b0};
        vecs[11] = '{1, 32'h100, 64'h12345678, 1'b1, 3'b010, 0, 64'h0, 1'b0};
        vecs[12] = '{1, 32'h100, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 3'b011, 0, 64'h0, 1'b1};
        vecs[13] = '{1, 32'h100, 64'h0, 1'b0, 3'b011, 0, 64'h0, 1'b1};
        vecs[14] = '{1, 32'h100, 64'h0, 1'b0, 3'b010, 2, 64'h12345678, 1'b0};
        vecs[15] = '{0, 32'h100, 64'h0, 1'b0, 3'b110, 0, 64'h0, 1'b1};
        vecs[16] = '{0, 32'h100, 64'h0, 1'b0, 3'b111, 0, 64'h0, 1'b1};
        vecs[17] = '{1, 32'h101, 64'h0, 1'b0, 3'b001, 0, 64'h0, 1'b1};
        vecs[18] = '{1, 32'h102, 64'h0, 1'b0, 3'b101, 0, 64'h1234, 1'b0};

        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
            req_we[i] = 1'b0; req_funct3[i] = '0; resp_ready[i] = 1'b0;
        end
        #23;
        for (int i = 0; i < 2; i++) begin
            check("rst_req_ready", req_ready[i], 1'b1);
            check("rst_resp_valid", resp_valid[i], 1'b0);
            check("rst_resp_error", resp_error[i], 1'b0);
            check("rst_resp_rdata", resp_rdata[i], 64'h0);
            check("rst_mem_read", mem_read[i], 1'b0);
            check("rst_mem_write", mem_write[i], 1'b0);
            check("rst_mem_addr", 64'(mem_addr[i]), 64'h0);
            check("rst_mem_wdata", mem_write_data[i], 64'h0);
            check("rst_mem_funct3", 64'(mem_funct3[i]), 64'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        // idle with req_valid low: nothing moves
        repeat (3) @(negedge clk);
        check("idle_stays", req_ready[0], 1'b1);
        check("idle_no_resp", resp_valid[0], 1'b0);

        foreach (vecs[v]) begin
            do_req(vecs[v].inst, vecs[v].addr, vecs[v].wdata, vecs[v].we, vecs[v].f3,
                   vecs[v].hold, rd, er, lat, nwr, nrd);
            check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            check($sformatf("vec%0d_error", v), er, vecs[v].exp_err);
            check($sformatf("vec%0d_latency", v), 64'(lat), vecs[v].exp_err ? 64'd1 : 64'd2);
            check($sformatf("vec%0d_writes", v), 64'(nwr),
                  (!vecs[v].exp_err && vecs[v].we) ? 64'd1 : 64'd0);
            check($sformatf("vec%0d_reads", v), 64'(nrd),
                  (!vecs[v].exp_err && !vecs[v].we) ? 64'd1 : 64'd0);
            if (!vecs[v].exp_err && vecs[v].we)
                model_store(vecs[v].inst, vecs[v].addr, vecs[v].wdata, vecs[v].f3);
        end

        // Reset during ACCESS of a store: write must not land
        @(negedge clk);
        req_addr[0] = 32'h300; req_wdata[0] = 64'hA5A5A5A5; req_we[0] = 1'b1;
        req_funct3[0] = 3'b010; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("rstacc_write_seen", mem_write[0], 1'b1);
        reset_n = 1'b0;
        #1;
        check("rstacc_write_drop", mem_write[0], 1'b0);
        check("rstacc_req_ready", req_ready[0], 1'b1);
        check("rstacc_resp_valid", resp_valid[0], 1'b0);
        check("rstacc_mem_addr", 64'(mem_addr[0]), 64'h0);
        check("rstacc_mem_wdata", mem_write_data[0], 64'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++)
            check($sformatf("rstacc_mem%0d", k), 64'(mem[0][32'h300 + k]),
                  64'(model_mem[0][32'h300 + k]));

        // Reset during RESP discards the response
        @(negedge clk);
        req_addr[0] = 32'h100; req_we[0] = 1'b0; req_funct3[0] = 3'b010; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("rstresp_valid_before", resp_valid[0], 1'b1);
        reset_n = 1'b0;
        #1;
        check("rstresp_valid_drop", resp_valid[0], 1'b0);
        check("rstresp_rdata", resp_rdata[0], 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic against the reference model
        for (int r = 0; r < 300; r++) begin
            int i;
            logic [31:0] a;
            logic w;
            logic [2:0] f3;
            logic [63:0] wd, exp_rd;
            bit exp_er;
            i  = int'($urandom_range(0, 1));
            a  = $urandom_range(0, 1015);
            if ($urandom_range(0, 1) == 1) a = a & ~32'h7;
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = {$urandom, $urandom};
            exp_er = model_err(i, w, f3, a);
            exp_rd = (exp_er || w) ? 64'h0 : model_load(i, a, f3);
            do_req(i, a, wd, w, f3, int'($urandom_range(0, 2)), rd, er, lat, nwr, nrd);
            check("rand_rdata", rd, exp_rd);
            check("rand_error", er, exp_er);
            check("rand_latency", 64'(lat), exp_er ? 64'd1 : 64'd2);
            check("rand_writes", 64'(nwr), (!exp_er && w) ? 64'd1 : 64'd0);
            if (!exp_er && w) model_store(i, a, wd, f3);
        end

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 1024; k++)
                if (mem[i][k] !== model_mem[i][k])
                    check($sformatf("final_mem%0d_%0d", i, k), 64'(mem[i][k]), 64'(model_mem[i][k]));
        check("final_idle", req_ready[1], 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_master.md
# dmem_master

Initiator-side sequencer for the data memory port. It accepts one load/store request at a time from the pipeline over a valid/ready handshake. It drives the combinational-read / posedge-write data memory interface for exactly one cycle, captures the load result, and returns a response over a second valid/ready handshake. Alignment and funct3 legality are checked before any memory cycle is issued.

## Interface
Parameters:
- XLEN, 32: integer width and address width (32 or 64).
- FLEN, 64: FP width (0/32/64); enables funct3 011 on RV32 when 64.
- ALLOW_MISALIGNED, 1: 1 forwards misaligned accesses to memory; 0 rejects them with resp_error.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  XLEN  byte address.
- req_wdata  in  64  store data, LSB-aligned.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V size/sign code.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  64  load result; 0 for stores and errors.
- resp_error  out  1  illegal funct3 or rejected misalignment.
- mem_addr  out  XLEN  to memory addr.
- mem_write_data  out  64  to memory write_data.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_funct3  out  3  to memory funct3.
- mem_read_data  in  64  combinational read data from memory.

## Operation
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid: register addr, wdata, we, funct3; compute error.
  - error=0 goes to ACCESS. error=1 goes to RESP with resp_error=1 and resp_rdata=0.
- Error conditions:
  - Store with funct3[2]=1.
  - Load with funct3=111.
  - funct3 011 when XLEN=32 and FLEN<64.
  - funct3 110 when XLEN=32.
  - ALLOW_MISALIGNED=0 and the address is not aligned for its size: half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
- ACCESS (exactly one cycle):
  - mem_read=~we, mem_write=we.
  - mem_addr, mem_write_data, mem_funct3 come from the request registers.
  - At the closing edge, load data is captured from mem_read_data unmodified (the memory already sign/zero-extends).
  - For stores, resp_rdata=0.
  - Always goes to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_error stay stable while resp_ready=0.
  - On resp_ready=1, go to IDLE.
- mem_read/mem_write are decoded from state only, never from req_* inputs. Outside ACCESS both are 0; mem_addr, mem_write_data and mem_funct3 hold their registered values.
- Requests are never overlapped: req_ready=0 in ACCESS and RESP.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_write_data=0, mem_funct3=0.
- Load/store latency: request handshake at edge E; ACCESS during cycle E+1; memory write and load capture at edge E+1; resp_valid high during cycle E+2.
- Error latency: resp_valid high during cycle E+1; no memory cycle is issued.
- Throughput: with resp_ready tied high, one request per 3 cycles (legal) or 2 cycles (error).
- The response handshake returns to IDLE at that edge; req_ready rises in the next cycle.
- Reset asserted mid-ACCESS forces IDLE immediately.
  - mem_write drops combinationally, so no write occurs at the next edge.
  - A write already committed at an earlier edge is not undone.
- Reset asserted mid-RESP discards the response; resp_valid drops immediately.
- req_valid deasserted in IDLE: no state change.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, funct3 010; then LW 0x100 -> mem_write pulse of exactly 1 cycle, E+2 response for both; load resp_rdata=0xFFFFFFFFDEADBEEF, resp_error=0.
- SB 0x203 = 0x80, then LB 0x203 -> resp_rdata=0xFFFFFFFFFFFFFF80; LBU 0x203 -> resp_rdata=0x0000000000000080.
- ALLOW_MISALIGNED=0, LW 0x102 -> resp_valid at E+1, resp_error=1, resp_rdata=0, mem_read never asserted. With ALLOW_MISALIGNED=1, the same LW returns the misaligned word with resp_error=0.
- Load held with resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_error stable; req_ready=0 throughout; IDLE one edge after resp_ready=1.
- Store with funct3 100, and (XLEN=32, FLEN=32) funct3 011 -> resp_error=1 at E+1; memory unchanged on readback.
- Pull reset_n low during the ACCESS of an SW to 0x300 -> mem_write=0 immediately, all outputs at reset values, mem[0x300..0x303] unchanged.
